// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared mode encodings, FSM state encoding and limits for the
//            CRC stream checker.
// Revision : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam int MODE_XOR = 0;
    localparam int MODE_CRC = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_COLLECT = 2'd0;
    localparam state_t ST_CHECK   = 2'd1;
    localparam state_t ST_REPORT  = 2'd2;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_word_step.sv
`default_nettype none
// ============================================================================
// Module   : crc_word_step
// Purpose  : Combinational next-accumulator for one data word (XOR or CRC).
// Revision : 1.0 - initial release
// ============================================================================
module crc_word_step
    import crc_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] KEY    = 8'h37,
    parameter int                MODE   = MODE_XOR
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] next_acc
);

    generate
        if (MODE == MODE_CRC) begin : g_crc
            // MSB-first serial CRC, unrolled across the whole word.
            always_comb begin
                logic [DATA_W-1:0] w_r;
                logic              w_fb;
                w_r  = acc;
                w_fb = 1'b0;
                for (int b = DATA_W - 1; b >= 0; b--) begin
                    w_fb = w_r[DATA_W-1] ^ word[b];
                    w_r  = {w_r[DATA_W-2:0], 1'b0} ^ (w_fb ? KEY : '0);
                end
                next_acc = w_r;
            end
        end else if (MODE == MODE_XOR) begin : g_xor
            assign next_acc = acc ^ word;
        end else begin : g_bad_mode
            $error("crc_word_step: MODE must be 0 or 1");
            assign next_acc = '0;
        end
    endgenerate

endmodule : crc_word_step
`default_nettype wire

// File: rtl/crc_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_stream_checker
// Purpose  : Accumulates FRAME_LEN words, compares the trailing check word and
//            holds the verdict until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] KEY       = 8'h37,
    parameter logic [DATA_W-1:0] INIT      = '0,
    parameter int                FRAME_LEN = 1,
    parameter int                MODE      = MODE_XOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_ok,
    output logic [15:0]       err_count
);

    generate
        if (DATA_W < 4 || DATA_W > 32) begin : g_bad_data_w
            $error("crc_stream_checker: DATA_W out of range 4..32");
        end
        if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
            $error("crc_stream_checker: FRAME_LEN out of range 1..255");
        end
    endgenerate

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_count;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_step_acc;
    logic [DATA_W-1:0] w_expected;
    logic              w_accept;
    logic              w_match;

    crc_word_step #(
        .DATA_W (DATA_W),
        .KEY    (KEY),
        .MODE   (MODE)
    ) u_step (
        .acc      (r_acc),
        .word     (in_data),
        .next_acc (w_step_acc)
    );

    generate
        if (MODE == MODE_XOR) begin : g_exp_xor
            assign w_expected = r_acc ^ KEY;
        end else begin : g_exp_crc
            assign w_expected = r_acc;
        end
    endgenerate

    assign w_accept = in_valid && in_ready;
    assign w_match  = (in_data == w_expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // abort outranks a simultaneous accept, but cannot touch a held verdict.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (abort)                                 w_next_state = ST_COLLECT;
                else if (w_accept && r_count == LAST_IDX)  w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)         w_next_state = ST_COLLECT;
                else if (w_accept) w_next_state = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) w_next_state = ST_COLLECT;
            end
            default: w_next_state = ST_COLLECT;
        endcase
    end

    always_comb begin
        in_ready = (r_state != ST_REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= INIT;
            r_count   <= '0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            err_count <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (abort) begin
                        r_acc   <= INIT;
                        r_count <= '0;
                    end else if (w_accept) begin
                        r_acc   <= w_step_acc;
                        r_count <= r_count + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        r_acc   <= INIT;
                        r_count <= '0;
                    end else if (w_accept) begin
                        res_ok    <= w_match;
                        res_valid <= 1'b1;
                        if (!w_match && err_count != ERR_MAX) begin
                            err_count <= err_count + 16'd1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_acc     <= INIT;
                        r_count   <= '0;
                    end
                end
                default: begin
                    r_acc   <= INIT;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule : crc_stream_checker
`default_nettype wire

// File: tb/tb_crc_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_stream_checker
// Purpose  : Three checker configurations driven by directed and random
//            traffic, compared each cycle against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_stream_checker;

    localparam int          NI = 3;
    localparam int          FLA   [NI] = '{1, 9, 4};
    localparam int          MODEA [NI] = '{0, 1, 1};
    localparam logic [7:0]  KEYA  [NI] = '{8'h37, 8'h07, 8'h1D};
    localparam logic [7:0]  INITA [NI] = '{8'h00, 8'h00, 8'hFF};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [7:0]  in_data   [NI];
    logic        abort     [NI];
    logic        res_valid [NI];
    logic        res_ready [NI];
    logic        res_ok    [NI];
    logic [15:0] err_count [NI];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit preset_req = 1'b0;
    bit preset_done = 1'b0;

    // frame-level model state
    logic [7:0]  m_frame   [NI][256];
    int          m_n       [NI];
    bit          m_pending [NI];
    bit          m_ok      [NI];
    logic [15:0] m_err     [NI];

    int nverd2 = 0;
    bit rv2_prev = 1'b0;

    always #5 clk = ~clk;

    crc_stream_checker #(.DATA_W(8), .KEY(8'h37), .INIT(8'h00), .FRAME_LEN(1), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .abort(abort[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_ok(res_ok[0]),
        .err_count(err_count[0]));
    crc_stream_checker #(.DATA_W(8), .KEY(8'h07), .INIT(8'h00), .FRAME_LEN(9), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .abort(abort[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_ok(res_ok[1]),
        .err_count(err_count[1]));
    crc_stream_checker #(.DATA_W(8), .KEY(8'h1D), .INIT(8'hFF), .FRAME_LEN(4), .MODE(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .abort(abort[2]), .res_valid(res_valid[2]), .res_ready(res_ready[2]), .res_ok(res_ok[2]),
        .err_count(err_count[2]));

    // Check word of a whole frame, straight from the checksum/CRC definitions.
    function automatic logic [7:0] calc(input int mode, input logic [7:0] key,
                                        input logic [7:0] init, input logic [7:0] w [256],
                                        input int n);
        logic [7:0] x;
        logic       fb;
        x = init;
        for (int k = 0; k < n; k++) begin
            if (mode == 0) begin
                x = x ^ w[k];
            end else begin
                for (int b = 7; b >= 0; b--) begin
                    fb = x[7] ^ w[k][b];
                    x  = {x[6:0], 1'b0} ^ (fb ? key : 8'h00);
                end
            end
        end
        return (mode == 0) ? (x ^ key) : x;
    endfunction

    function automatic logic [7:0] exp_check(input int i);
        logic [7:0] w [256];
        for (int k = 0; k < 256; k++) w[k] = m_frame[i][k];
        return calc(MODEA[i], KEYA[i], INITA[i], w, m_n[i]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst or posedge preset_req) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_n[i] = 0; m_pending[i] = 1'b0; m_ok[i] = 1'b0; m_err[i] = 16'h0;
            end
        end else if (preset_req && !preset_done) begin
            m_err[0]    = 16'hFFFE;
            preset_done = 1'b1;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_pending[i]) begin
                    if (res_ready[i]) begin
                        m_pending[i] = 1'b0;
                        m_n[i]       = 0;
                    end
                end else if (abort[i]) begin
                    m_n[i] = 0;
                end else if (in_valid[i]) begin
                    if (m_n[i] < FLA[i]) begin
                        m_frame[i][m_n[i]] = in_data[i];
                        m_n[i]++;
                    end else begin
                        m_ok[i]      = (in_data[i] == exp_check(i));
                        m_pending[i] = 1'b1;
                        if (!m_ok[i] && m_err[i] != 16'hFFFF) m_err[i] = m_err[i] + 16'd1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(!m_pending[i]));
                check($sformatf("res_valid[%0d]", i), 32'(res_valid[i]), 32'(m_pending[i]));
                if (m_pending[i]) check($sformatf("res_ok[%0d]", i), 32'(res_ok[i]), 32'(m_ok[i]));
                check($sformatf("err_count[%0d]", i), 32'(err_count[i]), 32'(m_err[i]));
            end
        end
        if (res_valid[2] && !rv2_prev) nverd2++;
        rv2_prev = res_valid[2];
    end

    task automatic send(input int i, input logic [7:0] d);
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_res(input int i);
        for (int k = 0; k < 20 && !res_valid[i]; k++) begin
            @(posedge clk); #1;
        end
        check($sformatf("verdict_timeout[%0d]", i), 32'(res_valid[i]), 32'd1);
    endtask

    task automatic ack(input int i);
        res_ready[i] = 1'b1;
        @(posedge clk); #1;
        res_ready[i] = 1'b0;
    endtask

    task automatic frame(input int i, input logic [7:0] w [256], input logic [7:0] chk,
                         input logic exp_ok);
        for (int k = 0; k < FLA[i]; k++) send(i, w[k]);
        send(i, chk);
        wait_res(i);
        check($sformatf("frame_ok[%0d]", i), 32'(res_ok[i]), 32'(exp_ok));
        ack(i);
    endtask

    initial begin
        logic [7:0] msg [256];
        logic [7:0] w   [256];
        int         v0;

        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 8'h00; abort[i] = 1'b0; res_ready[i] = 1'b0;
        end
        for (int k = 0; k < 256; k++) begin msg[k] = 8'h00; w[k] = 8'h00; end
        for (int k = 0; k < 9; k++) msg[k] = 8'h31 + 8'(k);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
            check($sformatf("rst_res_valid[%0d]", i), 32'(res_valid[i]), 32'd0);
            check($sformatf("rst_res_ok[%0d]", i), 32'(res_ok[i]), 32'd0);
            check($sformatf("rst_err[%0d]", i), 32'(err_count[i]), 32'd0);
        end
        rst = 1'b0;
        cmp_en = 1'b1;

        // pin the reference model to known answers
        w[0] = 8'hAA;
        check("model_xor_AA", 32'(calc(0, 8'h37, 8'h00, w, 1)), 32'h9D);
        w[0] = 8'hAF;
        check("model_xor_AF", 32'(calc(0, 8'h37, 8'h00, w, 1)), 32'h98);
        check("model_crc_123456789", 32'(calc(1, 8'h07, 8'h00, msg, 9)), 32'hF4);

        @(posedge clk); #1;
        // XOR checksum, single-word frames
        send(0, 8'hAA); send(0, 8'h9D); wait_res(0);
        check("xor_AA_9D_ok", 32'(res_ok[0]), 32'd1);
        check("xor_AA_9D_err", 32'(err_count[0]), 32'd0);
        ack(0);
        send(0, 8'hAA); send(0, 8'h9E); wait_res(0);
        check("xor_AA_9E_ok", 32'(res_ok[0]), 32'd0);
        check("xor_AA_9E_err", 32'(err_count[0]), 32'd1);
        ack(0);
        send(0, 8'hAF); send(0, 8'h98); wait_res(0);
        check("xor_AF_98_ok", 32'(res_ok[0]), 32'd1);
        ack(0);

        // CRC-8 poly 07 over "123456789"
        frame(1, msg, 8'hF4, 1'b1);
        frame(1, msg, 8'hF5, 1'b0);
        check("crc_err_after_bad", 32'(err_count[1]), 32'd1);

        // backpressure: verdict held, offered words ignored
        send(0, 8'hAA); send(0, 8'h9D);
        in_valid[0] = 1'b1; in_data[0] = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
            check("bp_res_valid", 32'(res_valid[0]), 32'd1);
            check("bp_res_ok", 32'(res_ok[0]), 32'd1);
        end
        in_valid[0] = 1'b0;
        ack(0);
        send(0, 8'hAF); send(0, 8'h98); wait_res(0);
        check("bp_restart_ok", 32'(res_ok[0]), 32'd1);
        ack(0);

        // abort after two words, abort outranking a simultaneous word
        v0 = nverd2;
        send(2, 8'(($urandom))); send(2, 8'(($urandom)));
        abort[2] = 1'b1; in_valid[2] = 1'b1; in_data[2] = 8'h5A;
        @(posedge clk); #1;
        abort[2] = 1'b0; in_valid[2] = 1'b0;
        for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
        frame(2, w, calc(1, 8'h1D, 8'hFF, w, 4), 1'b1);
        @(negedge clk); #1;
        check("abort_verdicts", 32'(nverd2 - v0), 32'd1);
        @(posedge clk); #1;

        // async reset with inst0 in REPORT and inst1 mid-frame
        send(0, 8'hAA); send(0, 8'h9E);
        for (int k = 0; k < 4; k++) send(1, msg[k]);
        #1 rst = 1'b1;
        #1;
        check("arst_res_valid0", 32'(res_valid[0]), 32'd0);
        check("arst_in_ready0", 32'(in_ready[0]), 32'd1);
        check("arst_err0", 32'(err_count[0]), 32'd0);
        check("arst_res_ok0", 32'(res_ok[0]), 32'd0);
        check("arst_err1", 32'(err_count[1]), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        frame(1, msg, 8'hF4, 1'b1);
        frame(0, msg, 8'h31 ^ 8'h37, 1'b1);

        // saturation of err_count
        force u_dut0.err_count = 16'hFFFE;
        #1 release u_dut0.err_count;
        preset_req = 1'b1;
        @(posedge clk); #1;
        w[0] = 8'hAA;
        frame(0, w, 8'h00, 1'b0);
        frame(0, w, 8'h01, 1'b0);
        check("err_saturated", 32'(err_count[0]), 32'hFFFF);

        // random traffic on all three instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                abort[i]     = ($urandom_range(0, 19) == 0);
                res_ready[i] = ($urandom_range(0, 2) != 0);
                if (!m_pending[i] && m_n[i] == FLA[i] && $urandom_range(0, 1) == 1)
                    in_data[i] = exp_check(i);
                else
                    in_data[i] = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0; abort[i] = 1'b0; res_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_crc_stream_checker
`default_nettype wire

// File: doc/crc_stream_checker.md
CRC_STREAM_CHECKER -- requirements
Module: crc_stream_checker

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: word width in bits, legal range 4..32.
REQ-002 SHALL provide parameter KEY, default 8'h37 (DATA_W bits): the XOR key in MODE 0 and the generator polynomial (implicit top bit) in MODE 1.
REQ-003 SHALL provide parameter INIT, default 0: the accumulator start value.
REQ-004 SHALL provide parameter FRAME_LEN, default 1: data words per frame, legal range 1..255.
REQ-005 SHALL provide parameter MODE, default 0: 0 selects XOR-key checksum (legacy-compatible), 1 selects bitwise CRC.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  in_data is presented.
REQ-009 in_ready  output  1  checker accepts a word this cycle.
REQ-010 in_data  input  DATA_W  data word, or the trailing check word.
REQ-011 abort  input  1  synchronous discard of the partial frame.
REQ-012 res_valid  output  1  a frame verdict is held.
REQ-013 res_ready  input  1  consumer takes the verdict.
REQ-014 res_ok  output  1  1 = check word matched, 0 = mismatch.
REQ-015 err_count  output  16  count of failed frames, saturating.

Function
REQ-016 A word SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; all other words are ignored without state change.
REQ-017 States SHALL be COLLECT, CHECK and REPORT; in_ready SHALL be 1 in COLLECT and CHECK and 0 in REPORT.
REQ-018 COLLECT: each accepted word SHALL update the accumulator and increment a word counter; the word that makes the count equal FRAME_LEN SHALL move the FSM to CHECK.
REQ-019 MODE 0 update SHALL be acc <= acc ^ word; expected check = acc ^ KEY. With FRAME_LEN=1 and INIT=0 this gives check = data ^ KEY.
REQ-020 MODE 1 update SHALL process the word MSB first, one accepted word per cycle: for each bit, fb = acc[MSB] ^ bit; acc = (acc<<1) ^ (fb ? KEY : 0); no reflection and no final XOR; expected check = acc.
REQ-021 CHECK: the next accepted word SHALL be compared with the expected value; res_ok is loaded, res_valid is set the following cycle, and the FSM moves to REPORT.
REQ-022 REPORT: res_valid and res_ok SHALL hold stable until res_ready=1; on that edge res_valid clears, acc returns to INIT, the counter to 0, and the FSM to COLLECT.
REQ-023 Latency SHALL be one cycle from acceptance of the check word to res_valid=1; when res_ready is already high, throughput is one frame per FRAME_LEN+2 cycles.
REQ-024 A mismatch SHALL increment err_count on the edge that sets res_valid; err_count SHALL saturate at 16'hFFFF.
REQ-025 abort=1 in COLLECT or CHECK SHALL return the FSM to COLLECT with acc=INIT and counter=0, with no verdict and no err_count change; abort has priority over a simultaneous accept.
REQ-026 abort SHALL be ignored in REPORT; the verdict is never lost.
REQ-027 res_ready SHALL be ignored outside REPORT.

Reset
REQ-028 rst=1 SHALL asynchronously force: FSM to COLLECT, acc=INIT, counter=0, res_valid=0, res_ok=0, err_count=0; in_ready=1 follows combinationally.
REQ-029 Reset mid-frame or mid-REPORT SHALL discard the frame and any pending verdict.

Structure
REQ-030 The mode encodings (MODE_XOR=0, MODE_CRC=1), the FSM state encoding and ERR_MAX=16'hFFFF SHALL live in a shared package, crc_pkg.
REQ-031 The per-word next-accumulator function SHALL be one combinational sub-module, crc_word_step (parameters DATA_W, KEY, MODE), so it can be reused by a future generator block.
REQ-032 No illegal parameter value SHALL be accepted silently: an out-of-range DATA_W or FRAME_LEN SHALL raise an elaboration-time error.

Verification
REQ-033 MODE 0, FRAME_LEN=1: AA then 9D -> res_ok=1, err_count=0; AA then 9E -> res_ok=0, err_count=1; AF then 98 -> res_ok=1.
REQ-034 MODE 1, KEY=8'h07, INIT=0, FRAME_LEN=9: ASCII "123456789" then F4 -> res_ok=1; same frame then F5 -> res_ok=0.
REQ-035 Backpressure: hold res_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and res_valid/res_ok stable; the held words are not consumed; frame restarts after the res_ready handshake.
REQ-036 Abort: FRAME_LEN=4, abort after 2 words, then a full valid frame -> exactly one verdict, res_ok=1.
REQ-037 Async reset asserted mid-frame and mid-REPORT between clock edges -> outputs reach reset values immediately; the next complete frame verifies correctly.
REQ-038 Force err_count to 16'hFFFE, then send two bad frames -> err_count ends at 16'hFFFF.
